score_seg13_scan: RTL and testbench

- Multi-digit 13-segment score display driver for the Tetris score panel.
- Accepts a binary score on a load strobe and converts it to packed BCD with a sequential double-dabble, one bit per cycle.
- Time-multiplexes NUM_DIGITS digits onto one shared 13-segment bus plus one-hot digit enables.
- Sits between the game scoring logic and the display pins.

---
 rtl/score_disp_pkg.sv | 44 ++++
 rtl/seg13_decode.sv | 36 +++
 rtl/score_seg13_scan.sv | 189 ++++++++++++++++++
 tb/tb_score_seg13_scan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// ----------------------------------------------------------------------------
// score_disp_pkg
// Shared definitions for the 13-segment score display:
//   SEG_W      - width of the segment bus (bit12 = a ... bit0 = m, 1 = lit)
//   SEG_PAT    - segment patterns for decimal digits 0..9
//   SEG_BLANK  - all segments off
//   state_e    - binary-to-BCD converter FSM states
//   pow10()    - 10^n, used for the compile-time overflow limit
// ----------------------------------------------------------------------------
package score_disp_pkg;

    localparam int SEG_W = 13;

    localparam logic [SEG_W-1:0] SEG_BLANK = 13'h0000;

    localparam logic [SEG_W-1:0] SEG_PAT [0:9] = '{
        13'h1FFE,  // 0
        13'h1F00,  // 1
        13'h1DBB,  // 2
        13'h1FD7,  // 3
        13'h1F1D,  // 4
        13'h17F7,  // 5
        13'h17FF,  // 6
        13'h1F06,  // 7
        13'h1FFF,  // 8
        13'h1F1F   // 9
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg13_decode.sv
// ----------------------------------------------------------------------------
// seg13_decode
// Combinational BCD nibble to 13-segment pattern lookup.
// Ports:
//   nibble_i  in  4      BCD digit; values 10..15 decode to all-off
//   blank_i   in  1      force all segments off
//   seg_o     out SEG_W  segment pattern, bit12 = a ... bit0 = m, 1 = lit
// ----------------------------------------------------------------------------
module seg13_decode
    import score_disp_pkg::*;
(
    input  logic [3:0]       nibble_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (nibble_i)
                4'd0:    seg_o = SEG_PAT[0];
                4'd1:    seg_o = SEG_PAT[1];
                4'd2:    seg_o = SEG_PAT[2];
                4'd3:    seg_o = SEG_PAT[3];
                4'd4:    seg_o = SEG_PAT[4];
                4'd5:    seg_o = SEG_PAT[5];
                4'd6:    seg_o = SEG_PAT[6];
                4'd7:    seg_o = SEG_PAT[7];
                4'd8:    seg_o = SEG_PAT[8];
                4'd9:    seg_o = SEG_PAT[9];
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_seg13_scan.sv
// ----------------------------------------------------------------------------
// score_seg13_scan
// Multi-digit 13-segment score display driver. A binary score captured on
// 'load' is converted to packed BCD by a sequential double-dabble (one bit
// per clock), committed to bcd_out, and time-multiplexed onto a shared
// segment bus with one-hot digit enables.
//
// Parameters:
//   BIN_W        width of the binary score
//   NUM_DIGITS   number of displayed decimal digits (1..8)
//   REFRESH_DIV  clocks each digit stays lit before the scan advances
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   score_bin  in   BIN_W         binary score, sampled on an accepted load
//   load       in   1             conversion request, accepted only in IDLE
//   busy       out  1             conversion in progress
//   overflow   out  1             last committed score exceeded 10^N-1
//   bcd_out    out  4*NUM_DIGITS  committed BCD, digit 0 in [3:0]
//   seg        out  13            pattern for the active digit
//   digit_en   out  NUM_DIGITS    one-hot active digit, bit 0 = LSD
//
// Build option:
//   SCORE_SEG13_LZ_BLANK_EN  when defined, digits above the highest non-zero
//                            committed digit are blanked (digit 0 never is).
// ----------------------------------------------------------------------------
module score_seg13_scan
    import score_disp_pkg::*;
#(
    parameter int BIN_W       = 14,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BIN_W-1:0]        score_bin,
    input  logic                    load,
    output logic                    busy,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [SEG_W-1:0]        seg,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int BCD_W    = 4 * NUM_DIGITS;
    localparam int CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BITCNT_W = $clog2(BIN_W + 1);

    localparam logic [63:0]         OVF_LIMIT = pow10(NUM_DIGITS);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BITCNT_W-1:0] BIT_LAST  = BITCNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0]    ALL_NINES = {NUM_DIGITS{4'h9}};

    // Converter state
    state_e                state_q;
    logic [BIN_W-1:0]      bin_q;
    logic [BCD_W-1:0]      scratch_q;
    logic [BCD_W-1:0]      scratch_adj;
    logic [BCD_W-1:0]      scratch_d;
    logic [BITCNT_W-1:0]   bit_cnt_q;
    logic                  ovf_pend_q;
    logic                  busy_q;
    logic                  ovf_q;
    logic [BCD_W-1:0]      bcd_q;

    // Scan state
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [SEG_W-1:0]      seg_q;
    logic [NUM_DIGITS-1:0] digit_en_q;
    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic [SEG_W-1:0]      cur_seg;

    // One double-dabble step: add 3 to every nibble >= 5, then shift the next
    // binary MSB in. Carries out of the top nibble are dropped; they only occur
    // for scores that overflow and are replaced by all-nines at commit.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_d = {scratch_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            bit_cnt_q  <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        bin_q      <= score_bin;
                        scratch_q  <= '0;
                        bit_cnt_q  <= '0;
                        ovf_pend_q <= (64'(score_bin) >= OVF_LIMIT);
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    bin_q     <= bin_q << 1;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    bcd_q   <= ovf_pend_q ? ALL_NINES : scratch_q;
                    ovf_q   <= ovf_pend_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cur_nibble = bcd_q[32'(idx_q) * 4 +: 4];

`ifdef SCORE_SEG13_LZ_BLANK_EN
    // lz_blank[i] is set when digit i and every digit above it are zero;
    // digit 0 is excluded so a zero score still shows a single "0".
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  run_zero;

    always_comb begin
        lz_blank = '0;
        run_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run_zero    = run_zero && (bcd_q[4*i +: 4] == 4'd0);
            lz_blank[i] = run_zero;
        end
    end

    assign cur_blank = lz_blank[idx_q];
`else
    assign cur_blank = 1'b0;
`endif

    seg13_decode u_decode (
        .nibble_i (cur_nibble),
        .blank_i  (cur_blank),
        .seg_o    (cur_seg)
    );

    // seg and digit_en are registered from the same index in the same cycle,
    // so the bus never shows one digit's pattern under another's enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            digit_en_q <= '0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            seg_q      <= cur_seg;
            digit_en_q <= NUM_DIGITS'(1) << idx_q;
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;
    assign seg      = seg_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_score_seg13_scan.sv
module tb_score_seg13_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] score_bin;
    logic        load;
    logic        busy;
    logic        overflow;
    logic [15:0] bcd_out;
    logic [12:0] seg;
    logic [3:0]  digit_en;

    int checks = 0;
    int errors = 0;

    logic [12:0] seg_ref [0:9] = '{13'h1FFE, 13'h1F00, 13'h1DBB, 13'h1FD7, 13'h1F1D,
                                   13'h17F7, 13'h17FF, 13'h1F06, 13'h1FFF, 13'h1F1F};

    always #5 clk = ~clk;

    score_seg13_scan #(
        .BIN_W       (14),
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .score_bin (score_bin),
        .load      (load),
        .busy      (busy),
        .overflow  (overflow),
        .bcd_out   (bcd_out),
        .seg       (seg),
        .digit_en  (digit_en)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse load for one cycle, then count cycles while busy is high (bounded).
    task automatic do_load(input int v, output int lat);
        score_bin = 14'(v);
        load = 1'b1;
        tick;
        load = 1'b0;
        lat = 0;
        while (busy === 1'b1 && lat < 100) begin
            lat++;
            tick;
        end
    endtask

    task automatic wait_digit(input logic [3:0] en, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (digit_en === en) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        if (v >= 10000) return 16'h9999;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic test_reset;
        logic [3:0]  exp_en;
        logic [12:0] exp_seg;
        rst_n = 1'b0;
        load = 1'b0;
        score_bin = '0;
        tick;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (bcd_out !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h expected 0000", bcd_out); end
        checks++; if (seg !== 13'h0000) begin errors++; $display("FAIL reset_seg: got %h expected 0000", seg); end
        checks++; if (digit_en !== 4'b0000) begin errors++; $display("FAIL reset_digit_en: got %b expected 0000", digit_en); end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick;
            exp_en = 4'b0001 << (((k - 1) / 4) % 4);
`ifdef SCORE_SEG13_LZ_BLANK_EN
            exp_seg = (exp_en == 4'b0001) ? 13'h1FFE : 13'h0000;
`else
            exp_seg = 13'h1FFE;
`endif
            checks++; if (digit_en !== exp_en) begin errors++; $display("FAIL scan_digit_en k=%0d: got %b expected %b", k, digit_en, exp_en); end
            checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg k=%0d: got %h expected %h", k, seg, exp_seg); end
        end
        checks++; if (bcd_out !== 16'h0000 || overflow !== 1'b0) begin errors++; $display("FAIL idle_bcd: got %h/%b expected 0000/0", bcd_out, overflow); end
    endtask

    task automatic test_convert;
        int lat;
        bit ok;
        logic [3:0]  nib;
        do_load(1234, lat);
        checks++; if (lat !== 15) begin errors++; $display("FAIL busy_len_1234: got %0d expected 15", lat); end
        checks++; if (bcd_out !== 16'h1234) begin errors++; $display("FAIL bcd_1234: got %h expected 1234", bcd_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_1234: got %b expected 0", overflow); end
        for (int d = 0; d < 4; d++) begin
            wait_digit(4'(1 << d), ok);
            nib = 4'(4 - d);
            checks++; if (!ok || seg !== seg_ref[nib]) begin errors++; $display("FAIL seg_1234 d%0d: got %h expected %h (found=%0d)", d, seg, seg_ref[nib], ok); end
        end
    endtask

    task automatic test_decode_map;
        int vals [4] = '{5678, 9999, 7, 0};
        int lat;
        bit ok;
        logic [15:0] exp;
        logic [3:0]  nib;
        logic [12:0] exp_seg;
        for (int j = 0; j < 4; j++) begin
            do_load(vals[j], lat);
            exp = to_bcd(vals[j]);
            checks++; if (bcd_out !== exp) begin errors++; $display("FAIL map_bcd %0d: got %h expected %h", vals[j], bcd_out, exp); end
            for (int d = 0; d < 4; d++) begin
                wait_digit(4'(1 << d), ok);
                nib = exp[4*d +: 4];
                exp_seg = seg_ref[nib];
`ifdef SCORE_SEG13_LZ_BLANK_EN
                if (d > 0 && (exp >> (4 * d)) == 16'h0) exp_seg = 13'h0000;
`endif
                checks++; if (!ok || seg !== exp_seg) begin errors++; $display("FAIL map_seg %0d d%0d: got %h expected %h (found=%0d)", vals[j], d, seg, exp_seg, ok); end
            end
        end
    endtask

    task automatic test_overflow;
        int lat;
        do_load(9999, lat);
        checks++; if (bcd_out !== 16'h9999 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_9999: got %h/%b expected 9999/0", bcd_out, overflow); end
        do_load(12000, lat);
        checks++; if (bcd_out !== 16'h9999 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_12000: got %h/%b expected 9999/1", bcd_out, overflow); end
        checks++; if (lat !== 15) begin errors++; $display("FAIL busy_len_12000: got %0d expected 15", lat); end
        do_load(7, lat);
        checks++; if (bcd_out !== 16'h0007 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_7: got %h/%b expected 0007/0", bcd_out, overflow); end
    endtask

    task automatic test_back_to_back;
        int lat;
        score_bin = 14'd5678;
        load = 1'b1;
        tick;
        load = 1'b0;
        lat = 0;
        while (busy === 1'b1 && lat < 100) begin
            lat++;
            // Second request mid-conversion, third during the commit cycle.
            if (lat == 5 || lat == 15) begin
                score_bin = 14'd42;
                load = 1'b1;
            end
            tick;
            load = 1'b0;
        end
        checks++; if (lat !== 15) begin errors++; $display("FAIL drop_busy_len: got %0d expected 15", lat); end
        checks++; if (bcd_out !== 16'h5678) begin errors++; $display("FAIL drop_bcd: got %h expected 5678", bcd_out); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_commit_load: busy got %b expected 0", busy); end
        tick;
        tick;
        checks++; if (bcd_out !== 16'h5678) begin errors++; $display("FAIL drop_bcd_hold: got %h expected 5678", bcd_out); end
    endtask

    task automatic test_reset_mid;
        int lat;
        do_load(12000, lat);
        score_bin = 14'd1111;
        load = 1'b1;
        tick;
        load = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (bcd_out !== 16'h0000) begin errors++; $display("FAIL mid_bcd: got %h expected 0000", bcd_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", overflow); end
        checks++; if (seg !== 13'h0000 || digit_en !== 4'b0000) begin errors++; $display("FAIL mid_display: got %h/%b expected 0000/0000", seg, digit_en); end
        tick;
        rst_n = 1'b1;
        tick;
        do_load(300, lat);
        checks++; if (bcd_out !== 16'h0300) begin errors++; $display("FAIL post_reset_bcd: got %h expected 0300", bcd_out); end
        checks++; if (lat !== 15) begin errors++; $display("FAIL post_reset_busy_len: got %0d expected 15", lat); end
    endtask

    task automatic test_sweep;
        int extra [7] = '{9998, 9999, 10000, 10001, 16383, 1, 10};
        int lat;
        int v;
        logic [15:0] exp;
        for (int n = 0; n < 170; n++) begin
            v = (n < 163) ? n * 101 : extra[n - 163];
            do_load(v, lat);
            exp = to_bcd(v);
            checks++; if (bcd_out !== exp) begin errors++; $display("FAIL sweep_bcd %0d: got %h expected %h", v, bcd_out, exp); end
            checks++; if (overflow !== (v >= 10000)) begin errors++; $display("FAIL sweep_ovf %0d: got %b expected %b", v, overflow, (v >= 10000)); end
        end
        for (int n = 0; n < 7; n++) begin
            v = extra[n];
            do_load(v, lat);
            exp = to_bcd(v);
            checks++; if (bcd_out !== exp || overflow !== (v >= 10000)) begin errors++; $display("FAIL edge_%0d: got %h/%b expected %h/%b", v, bcd_out, overflow, exp, (v >= 10000)); end
        end
    endtask

    initial begin
        test_reset;
        test_convert;
        test_decode_map;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
